// File: rtl/axis_pkt_replay_master_if.sv
// axis_pkt_replay_master_if: AXI4-Stream bundle between the replay master and its sink
interface axis_pkt_replay_master_if #(
  parameter int TDATA_WIDTH = 256
);
  logic                     tvalid;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic                     tready;
  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_pkt_replay_master.sv
// axis_pkt_replay_master: replays packets from a loadable beat memory and gap table onto an AXI4-Stream master
module axis_pkt_replay_master #(
  parameter int TDATA_WIDTH = 256,
  parameter int MEM_DEPTH = 1024,
  parameter int MAX_PKTS = 64,
  localparam int KB = TDATA_WIDTH / 8,
  localparam int EW = TDATA_WIDTH + KB + 1,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int KW = $clog2(MAX_PKTS) + 1,
  localparam int GW = MAX_PKTS > 1 ? $clog2(MAX_PKTS) : 1
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          START,
  input  logic          STOP,
  input  logic [KW-1:0] NUM_PKTS,
  input  logic [15:0]   LOOPS,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [31:0]   PKT_COUNT,
  input  logic          MEM_WE,
  input  logic [AW-1:0] MEM_ADDR,
  input  logic [EW-1:0] MEM_WDATA,
  input  logic          GAP_WE,
  input  logic [GW-1:0] GAP_ADDR,
  input  logic [15:0]   GAP_WDATA,
  axis_pkt_replay_master_if.master m_axis
);
  typedef enum logic [1:0] {S_IDLE, S_GAP, S_SEND, S_DONE} state_t;
  state_t state, state_nxt;
  logic [EW-1:0] beat_mem [MEM_DEPTH];
  logic [15:0] gap_mem [MAX_PKTS];
  logic [EW-1:0] beat;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [KW-1:0] k, k_nxt, num, num_nxt;
  logic [15:0] loops, loops_nxt, cnt, cnt_nxt;
  logic [31:0] pkts, pkts_nxt;
  logic err, err_nxt, send, hs, mem_end, overrun, last, pass_end;
  assign send = state == S_SEND;
  assign hs = send & m_axis.tready;
  assign mem_end = ptr == AW'(MEM_DEPTH - 1);
  // a packet running off the end of memory is closed and ends the pass
  assign overrun = mem_end & ~beat[EW-1];
  assign last = beat[EW-1] | mem_end;
  assign pass_end = overrun | (k + KW'(1) == num);
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    k_nxt = k;
    num_nxt = num;
    loops_nxt = loops;
    cnt_nxt = cnt;
    pkts_nxt = pkts;
    err_nxt = err;
    case (state)
      S_GAP: begin
        cnt_nxt = cnt == 16'd0 ? cnt : cnt - 16'd1;
        state_nxt = STOP ? S_DONE : cnt == 16'd0 ? S_SEND : S_GAP;
      end
      S_SEND: if (hs) begin
        ptr_nxt = mem_end ? '0 : ptr + AW'(1);
        if (last) begin
          pkts_nxt = &pkts ? pkts : pkts + 32'd1;
          err_nxt = err | overrun;
          k_nxt = pass_end ? '0 : k + KW'(1);
          ptr_nxt = pass_end ? '0 : ptr_nxt;
          loops_nxt = pass_end && loops != 16'd0 ? loops - 16'd1 : loops;
          cnt_nxt = gap_mem[k_nxt[GW-1:0]];
          state_nxt = STOP || (pass_end && loops == 16'd1) ? S_DONE : S_GAP;
        end
      end
      default: if (START) begin
        num_nxt = NUM_PKTS;
        loops_nxt = LOOPS;
        pkts_nxt = '0;
        err_nxt = 1'b0;
        ptr_nxt = '0;
        k_nxt = '0;
        cnt_nxt = gap_mem[0];
        state_nxt = NUM_PKTS == '0 ? S_DONE : S_GAP;
      end
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= S_IDLE;
      ptr <= '0;
      k <= '0;
      num <= '0;
      loops <= '0;
      cnt <= '0;
      pkts <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      k <= k_nxt;
      num <= num_nxt;
      loops <= loops_nxt;
      cnt <= cnt_nxt;
      pkts <= pkts_nxt;
      err <= err_nxt;
    end
  end
  // read address is the next pointer, so the register always holds mem[ptr] without a bubble
  always_ff @(posedge ACLK) begin
    beat <= beat_mem[ptr_nxt];
    if (MEM_WE) beat_mem[MEM_ADDR] <= MEM_WDATA;
    if (GAP_WE) gap_mem[GAP_ADDR] <= GAP_WDATA;
  end
  assign m_axis.tvalid = send;
  assign m_axis.tdata = send ? beat[TDATA_WIDTH-1:0] : '0;
  assign m_axis.tkeep = send ? beat[TDATA_WIDTH +: KB] : '0;
  assign m_axis.tlast = send & last;
  assign BUSY = state == S_GAP || send;
  assign DONE = state == S_DONE;
  assign ERR = err;
  assign PKT_COUNT = pkts;
endmodule

// File: tb/tb_axis_pkt_replay_master.sv
// tb_axis_pkt_replay_master: directed checks of packet replay, gaps, loops, stop, overrun and reset
module tb_axis_pkt_replay_master;
  localparam int W = 64;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0, stop = 1'b0;
  logic [3:0] num_pkts = '0;
  logic [15:0] loops = '0;
  logic we = 1'b0, we2 = 1'b0, gwe = 1'b0, gwe2 = 1'b0;
  logic [3:0] mem_addr = '0;
  logic [72:0] mem_data = '0;
  logic [2:0] gap_addr = '0;
  logic [15:0] gap_data = '0;
  logic busy1, done1, err1, busy2, done2, err2;
  logic [31:0] cnt1, cnt2;
  int tests = 0, fails = 0;
  int last_hs, done_at;
  logic [72:0] img [4];
  logic [72:0] got [$];
  axis_pkt_replay_master_if #(.TDATA_WIDTH(W)) ax1 ();
  axis_pkt_replay_master_if #(.TDATA_WIDTH(W)) ax2 ();
  axis_pkt_replay_master #(.TDATA_WIDTH(W), .MEM_DEPTH(16), .MAX_PKTS(8)) dut (
    .ACLK(clk), .ARESET(rst), .START(start), .STOP(stop), .NUM_PKTS(num_pkts), .LOOPS(loops),
    .BUSY(busy1), .DONE(done1), .ERR(err1), .PKT_COUNT(cnt1),
    .MEM_WE(we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_data),
    .GAP_WE(gwe), .GAP_ADDR(gap_addr), .GAP_WDATA(gap_data), .m_axis(ax1)
  );
  axis_pkt_replay_master #(.TDATA_WIDTH(W), .MEM_DEPTH(4), .MAX_PKTS(4)) dut2 (
    .ACLK(clk), .ARESET(rst), .START(start2), .STOP(stop), .NUM_PKTS(num_pkts[2:0]), .LOOPS(loops),
    .BUSY(busy2), .DONE(done2), .ERR(err2), .PKT_COUNT(cnt2),
    .MEM_WE(we2), .MEM_ADDR(mem_addr[1:0]), .MEM_WDATA(mem_data),
    .GAP_WE(gwe2), .GAP_ADDR(gap_addr[1:0]), .GAP_WDATA(gap_data), .m_axis(ax2)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic collect(input int budget, input logic [3:0] pat, input int stop_at);
    logic [72:0] held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    got.delete();
    done_at = -1;
    last_hs = -1;
    for (int i = 0; i < budget; i++) begin
      if (done1) begin
        done_at = i;
        break;
      end
      ax1.tready = pat[i[1:0]];
      if (stalled) chk("hold_stable", 80'({ax1.tvalid, ax1.tlast, ax1.tkeep, ax1.tdata}), 80'({1'b1, held}));
      if (ax1.tvalid && ax1.tready) begin
        got.push_back({ax1.tlast, ax1.tkeep, ax1.tdata});
        last_hs = i;
      end
      stalled = ax1.tvalid && !ax1.tready;
      held = {ax1.tlast, ax1.tkeep, ax1.tdata};
      if (got.size() == stop_at) stop = 1'b1;
      tick();
    end
    chk("done_reached", 80'(done_at >= 0), 80'(1));
    chk("done_after_last", 80'(done_at), 80'(last_hs + 1));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    ax1.tready = 1'b1;
    ax2.tready = 1'b1;
    img[0] = {1'b0, 8'hFF, 64'h11};
    img[1] = {1'b0, 8'hFF, 64'h22};
    img[2] = {1'b1, 8'hFF, 64'h33};
    img[3] = {1'b1, 8'h0F, 64'h44};
    tick();
    we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_addr = i[3:0];
      mem_data = img[i];
      tick();
    end
    we = 1'b0;
    we2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_addr = i[3:0];
      mem_data = {1'b0, 8'hFF, 64'hA0 + 64'(i)};
      tick();
    end
    we2 = 1'b0;
    gwe = 1'b1;
    gwe2 = 1'b1;
    gap_addr = 3'd0;
    gap_data = 16'd0;
    tick();
    gwe2 = 1'b0;
    gap_addr = 3'd1;
    gap_data = 16'd4;
    tick();
    gwe = 1'b0;
    gwe2 = 1'b1;
    gap_data = 16'd0;
    tick();
    gwe2 = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_stream", 80'({ax1.tvalid, ax1.tlast, ax1.tkeep, ax1.tdata}), 80'(0));
    chk("rst_status", 80'({busy1, done1, err1}), 80'(0));
    chk("rst_count", 80'(cnt1), 80'(0));
    // basic pass: 3-beat packet, gap of 4, 1-beat packet
    num_pkts = 4'd2;
    loops = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t0_busy_novalid", 80'({busy1, ax1.tvalid}), 80'(2'b10));
    tick();
    chk("t1_beat0", 80'({ax1.tvalid, ax1.tlast, ax1.tkeep, ax1.tdata}), 80'({1'b1, img[0]}));
    tick();
    chk("t2_beat1", 80'({ax1.tvalid, ax1.tlast, ax1.tkeep, ax1.tdata}), 80'({1'b1, img[1]}));
    tick();
    chk("t3_beat2", 80'({ax1.tvalid, ax1.tlast, ax1.tkeep, ax1.tdata}), 80'({1'b1, img[2]}));
    tick();
    chk("t4_gap", 80'({ax1.tvalid, busy1}), 80'(2'b01));
    chk("t4_count", 80'(cnt1), 80'(1));
    repeat (4) tick();
    chk("t8_still_gap", 80'(ax1.tvalid), 80'(0));
    tick();
    chk("t9_beat3", 80'({ax1.tvalid, ax1.tlast, ax1.tkeep, ax1.tdata}), 80'({1'b1, img[3]}));
    tick();
    chk("t10_done", 80'({done1, busy1, ax1.tvalid, err1}), 80'(4'b1000));
    chk("t10_count", 80'(cnt1), 80'(2));
    // backpressure
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(200, 4'b1001, -1);
    chk("bp_beats", 80'(got.size()), 80'(4));
    for (int j = 0; j < got.size(); j++) chk("bp_order", 80'(got[j]), 80'(img[j % 4]));
    chk("bp_count", 80'(cnt1), 80'(2));
    // three loops
    loops = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(300, 4'b1111, -1);
    chk("loop3_beats", 80'(got.size()), 80'(12));
    for (int j = 0; j < got.size(); j++) chk("loop3_order", 80'(got[j]), 80'(img[j % 4]));
    chk("loop3_count", 80'(cnt1), 80'(6));
    // endless loop, stop during 2nd beat of pkt0 in the second pass
    loops = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(300, 4'b1111, 6);
    chk("stop_beats", 80'(got.size()), 80'(7));
    for (int j = 0; j < got.size(); j++) chk("stop_order", 80'(got[j]), 80'(img[j % 4]));
    chk("stop_count", 80'(cnt1), 80'(3));
    repeat (3) tick();
    chk("stop_quiet", 80'({ax1.tvalid, done1}), 80'(2'b01));
    stop = 1'b0;
    // stop while in gap
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b1;
    tick();
    chk("gapstop_done", 80'({done1, busy1, ax1.tvalid}), 80'(3'b100));
    chk("gapstop_count", 80'(cnt1), 80'(0));
    stop = 1'b0;
    // reset in the middle of a packet
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", 80'({ax1.tvalid, ax1.tdata}), 80'({1'b1, 64'h22}));
    rst = 1'b1;
    tick();
    chk("midrst_stream", 80'({ax1.tvalid, ax1.tlast, ax1.tkeep, ax1.tdata}), 80'(0));
    chk("midrst_status", 80'({busy1, done1, err1, cnt1}), 80'(0));
    rst = 1'b0;
    // zero packets
    num_pkts = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 80'({done1, busy1, ax1.tvalid}), 80'(3'b100));
    repeat (3) tick();
    chk("zero_novalid", 80'({done1, ax1.tvalid}), 80'(2'b10));
    // memory overrun on a 4-entry memory with no tlast stored
    num_pkts = 4'd2;
    loops = 16'd1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    chk("ovr_beat0", 80'({ax2.tvalid, ax2.tlast, ax2.tkeep, ax2.tdata}), 80'({2'b10, 8'hFF, 64'hA0}));
    tick();
    chk("ovr_beat1", 80'({ax2.tvalid, ax2.tlast, ax2.tkeep, ax2.tdata}), 80'({2'b10, 8'hFF, 64'hA1}));
    tick();
    chk("ovr_beat2", 80'({ax2.tvalid, ax2.tlast, ax2.tdata}), 80'({2'b10, 64'hA2}));
    tick();
    chk("ovr_beat3", 80'({ax2.tvalid, ax2.tlast, ax2.tkeep, ax2.tdata}), 80'({2'b11, 8'hFF, 64'hA3}));
    chk("ovr_err_before", 80'(err2), 80'(0));
    tick();
    chk("ovr_end", 80'({done2, err2, ax2.tvalid, busy2}), 80'(4'b1100));
    chk("ovr_count", 80'(cnt2), 80'(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
